// File: rtl/wm_phase_timer.sv
// Washing-machine phase timer. It times each active phase of the controller
// against its duration and returns one-cycle completion and watchdog events.
// A lid-open condition pauses the countdown. Repeated rinse passes are
// sequenced internally.
module wm_phase_timer #(
    parameter int CLK_DIV      = 1000,
    parameter int CNT_W        = 16,
    parameter int FILL_TIME    = 20,
    parameter int HEAT_TIME    = 30,
    parameter int WASH_TIME    = 60,
    parameter int RINSE_TIME   = 25,
    parameter int RINSE_PASSES = 2,
    parameter int SPIN_TIME    = 40,
    parameter int WDOG_TIME    = 100
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [2:0]                          state,
    input  logic                                sig_Lid_Closed,
    output logic                                sig_Full,
    output logic                                sig_Temperature,
    output logic                                sig_Completed,
    output logic                                sig_Time_Out,
    output logic [CNT_W-1:0]                    remaining,
    output logic [$clog2(RINSE_PASSES+1)-1:0]   rinse_pass
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_FILL  = 3'd2,
        ST_HEAT  = 3'd3,
        ST_WASH  = 3'd4,
        ST_RINSE = 3'd5,
        ST_SPIN  = 3'd6,
        ST_FAULT = 3'd7
    } wm_state_e;

    localparam int RP_W = $clog2(RINSE_PASSES + 1);
    // A prescaler of at least one bit keeps CLK_DIV=1 legal (it then sits at 0).
    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam longint LIM = 64'd1 << CNT_W;

    localparam logic [CNT_W-1:0] FILL_T  = CNT_W'(FILL_TIME);
    localparam logic [CNT_W-1:0] HEAT_T  = CNT_W'(HEAT_TIME);
    localparam logic [CNT_W-1:0] WASH_T  = CNT_W'(WASH_TIME);
    localparam logic [CNT_W-1:0] RINSE_T = CNT_W'(RINSE_TIME);
    localparam logic [CNT_W-1:0] SPIN_T  = CNT_W'(SPIN_TIME);
    localparam logic [CNT_W-1:0] WDOG_T  = CNT_W'(WDOG_TIME);
    localparam logic [PW-1:0]    PRE_LD  = PW'(CLK_DIV - 1);
    localparam logic [RP_W-1:0]  LAST_RP = RP_W'(RINSE_PASSES - 1);

    // Durations that do not fit the counters would silently wrap, so stop elaboration instead.
    generate
        if (FILL_TIME >= LIM || HEAT_TIME >= LIM || WASH_TIME >= LIM ||
            RINSE_TIME >= LIM || SPIN_TIME >= LIM || WDOG_TIME >= LIM ||
            CLK_DIV < 1 || RINSE_PASSES < 1) begin : g_param_err
            $error("wm_phase_timer: illegal parameter set");
        end
    endgenerate

    wm_state_e          state_q;
    logic [PW-1:0]      presc;
    logic [CNT_W-1:0]   wdog;
    logic               done;
    logic               wdog_done;

    logic               entry;
    logic               timed;
    logic               tick;
    logic               last_pass;
    logic [CNT_W-1:0]   duration;

    // Decode phase entry, tick and the duration of the incoming phase.
    always_comb begin
        entry     = (state != state_q);
        timed     = state_q inside {ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN};
        tick      = (presc == '0);
        last_pass = (rinse_pass == LAST_RP);
        duration  = '0;
        case (wm_state_e'(state))
            ST_FILL:  duration = FILL_T;
            ST_HEAT:  duration = HEAT_T;
            ST_WASH:  duration = WASH_T;
            ST_RINSE: duration = RINSE_T;
            ST_SPIN:  duration = SPIN_T;
            default:  duration = '0;
        endcase
    end

    // Phase countdown, rinse sequencing, watchdog, and the registered event pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            presc           <= '0;
            remaining       <= '0;
            wdog            <= '0;
            done            <= 1'b0;
            wdog_done       <= 1'b0;
            rinse_pass      <= '0;
            sig_Full        <= 1'b0;
            sig_Temperature <= 1'b0;
            sig_Completed   <= 1'b0;
            sig_Time_Out    <= 1'b0;
        end else begin
            state_q         <= wm_state_e'(state);
            sig_Full        <= 1'b0;
            sig_Temperature <= 1'b0;
            sig_Completed   <= 1'b0;
            sig_Time_Out    <= 1'b0;
            if (entry) begin
                // A phase change discards any expiry pending from the old phase.
                remaining  <= duration;
                presc      <= PRE_LD;
                wdog       <= '0;
                done       <= 1'b0;
                wdog_done  <= 1'b0;
                rinse_pass <= '0;
            end else if (!timed) begin
                remaining <= '0;
                wdog      <= '0;
            end else begin
                presc <= tick ? PRE_LD : presc - 1'b1;
                if (!done) begin
                    if (remaining == '0) begin
                        case (state_q)
                            ST_FILL: begin
                                sig_Full <= 1'b1;
                                done     <= 1'b1;
                            end
                            ST_HEAT: begin
                                sig_Temperature <= 1'b1;
                                done            <= 1'b1;
                            end
                            ST_RINSE: begin
                                if (last_pass) begin
                                    sig_Completed <= 1'b1;
                                    done          <= 1'b1;
                                end else begin
                                    rinse_pass <= rinse_pass + 1'b1;
                                    remaining  <= RINSE_T;
                                end
                            end
                            default: begin
                                sig_Completed <= 1'b1;
                                done          <= 1'b1;
                            end
                        endcase
                    end else if (tick && sig_Lid_Closed) begin
                        remaining <= remaining - 1'b1;
                    end
                end
                // The watchdog ignores the lid so a phase stalled by an open lid still times out.
                if (tick && wdog != WDOG_T)
                    wdog <= wdog + 1'b1;
                if (wdog == WDOG_T && !wdog_done) begin
                    sig_Time_Out <= 1'b1;
                    wdog_done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer. Two instances share the inputs: one has a
// divide-by-4 prescaler and the other ticks on every clock.
module tb_wm_phase_timer;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] state   = 3'd0;
    logic       lid     = 1'b1;

    logic       a_full, a_temp, a_comp, a_to;
    logic [7:0] a_rem;
    logic [1:0] a_pass;
    logic       b_full, b_temp, b_comp, b_to;
    logic [7:0] b_rem;
    logic [1:0] b_pass;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    wm_phase_timer #(
        .CLK_DIV(4), .CNT_W(8), .FILL_TIME(3), .HEAT_TIME(0), .WASH_TIME(20),
        .RINSE_TIME(2), .RINSE_PASSES(3), .SPIN_TIME(5), .WDOG_TIME(8)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .state(state), .sig_Lid_Closed(lid),
        .sig_Full(a_full), .sig_Temperature(a_temp), .sig_Completed(a_comp),
        .sig_Time_Out(a_to), .remaining(a_rem), .rinse_pass(a_pass)
    );

    wm_phase_timer #(
        .CLK_DIV(1), .CNT_W(8), .FILL_TIME(3), .HEAT_TIME(0), .WASH_TIME(20),
        .RINSE_TIME(2), .RINSE_PASSES(3), .SPIN_TIME(5), .WDOG_TIME(8)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .state(state), .sig_Lid_Closed(lid),
        .sig_Full(b_full), .sig_Temperature(b_temp), .sig_Completed(b_comp),
        .sig_Time_Out(b_to), .remaining(b_rem), .rinse_pass(b_pass)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Park in IDLE, then present a new phase at a falling edge; the next rising edge is the entry edge.
    task automatic go(input logic [2:0] s);
        state = 3'd0;
        lid   = 1'b1;
        repeat (2) @(negedge clock);
        state = s;
    endtask

    initial begin
        int cnt, pos, cnt2, pos2;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_rem", b_rem, 0);
        check("rst_pulses", {a_full, a_temp, a_comp, a_to, b_full, b_temp, b_comp, b_to}, 0);
        reset_n = 1'b1;

        // FILL with a divide-by-4 prescaler: 3 ticks x 4 + 1 cycles to sig_Full
        go(3'd2);
        cnt = 0; pos = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            case (k)
                0:  check("fill_a_rem0", a_rem, 3);
                4:  check("fill_a_rem4", a_rem, 2);
                8:  check("fill_a_rem8", a_rem, 1);
                12: check("fill_a_rem12", a_rem, 0);
                default: ;
            endcase
            if (a_full) begin cnt++; pos = k; end
        end
        check("fill_a_pulses", cnt, 1);
        check("fill_a_pos", pos, 13);

        // Three rinse passes with a single completion at the end
        go(3'd5);
        cnt = 0; pos = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            case (k)
                0: begin check("rinse_rem0", b_rem, 2); check("rinse_pass0", b_pass, 0); end
                3: begin check("rinse_rem3", b_rem, 2); check("rinse_pass3", b_pass, 1); end
                6: begin check("rinse_rem6", b_rem, 2); check("rinse_pass6", b_pass, 2); end
                default: ;
            endcase
            if (b_comp) begin cnt++; pos = k; end
        end
        check("rinse_comp_cnt", cnt, 1);
        check("rinse_comp_pos", pos, 9);

        // Lid open for 10 ticks during FILL; watchdog fires during the pause
        go(3'd2);
        cnt = 0; pos = -1; cnt2 = 0; pos2 = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            case (k)
                1:  check("pause_rem1", b_rem, 2);
                6:  check("pause_rem6", b_rem, 2);
                11: check("pause_rem11", b_rem, 2);
                12: check("pause_rem12", b_rem, 1);
                13: check("pause_rem13", b_rem, 0);
                default: ;
            endcase
            if (b_full) begin cnt++; pos = k; end
            if (b_to)   begin cnt2++; pos2 = k; end
            if (k == 1)  lid = 1'b0;
            if (k == 11) lid = 1'b1;
        end
        check("pause_full_cnt", cnt, 1);
        check("pause_full_pos", pos, 14);
        check("pause_to_cnt", cnt2, 1);
        check("pause_to_pos", pos2, 9);

        // Zero-length HEAT expires right after entry
        go(3'd3);
        @(negedge clock);
        check("heat0_rem", b_rem, 0);
        check("heat0_k0", b_temp, 0);
        @(negedge clock);
        check("heat0_k1", b_temp, 1);
        @(negedge clock);
        check("heat0_k2", b_temp, 0);

        // Leave FILL on the cycle its expiry would register: no stale sig_Full
        go(3'd2);
        cnt = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            if (k == 3) begin
                check("stale_rem3", b_rem, 0);
                state = 3'd4;
            end
            if (k == 4) check("stale_wash_rem", b_rem, 20);
            if (k == 5) check("stale_wash_rem5", b_rem, 19);
            if (b_full) cnt++;
        end
        check("stale_full_cnt", cnt, 0);

        // Reset in the middle of WASH, then restart with WASH still requested
        go(3'd4);
        repeat (4) @(negedge clock);
        check("wash_rem17", b_rem, 17);
        reset_n = 1'b0;
        #1;
        check("midrst_rem", b_rem, 0);
        check("midrst_pass", b_pass, 0);
        check("midrst_pulses", {b_full, b_temp, b_comp, b_to}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("restart_rem0", b_rem, 20);
        @(negedge clock);
        check("restart_rem1", b_rem, 19);

        // Hold SPIN long after completion
        go(3'd6);
        cnt = 0; pos = -1; cnt2 = 0;
        for (int k = 0; k < 210; k++) begin
            @(negedge clock);
            if (b_comp) begin cnt++; pos = k; end
            if (b_to) cnt2++;
        end
        check("spin_comp_cnt", cnt, 1);
        check("spin_comp_pos", pos, 6);
        check("spin_to_cnt", cnt2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
